// File: rtl/instr_mem_arbiter.sv
// instr_mem_arbiter: round-robin arbiter sharing one instruction-memory request
// port among NUM_REQ miss requesters, one transaction outstanding at a time.
// Optional same-line request merging is compiled in with INSTR_ARB_MERGE_EN.
module instr_mem_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int LANE_WIDTH  = 512,
  parameter int OFFSET_BITS = 6
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  req_address_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  output logic [NUM_REQ-1:0]                  resp_valid_o,
  output logic [LANE_WIDTH-1:0]               resp_data_o,
  output logic [ADDR_WIDTH-1:0]               resp_address_o,
  input  logic                                mem_request_available_i,
  output logic                                mem_request_valid_o,
  output logic [ADDR_WIDTH-1:0]               mem_request_address_o,
  input  logic                                mem_response_valid_i,
  input  logic [LANE_WIDTH-1:0]               mem_response_data_i,
  output logic                                busy_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_MEM} state_e;

  state_e                  state_q;
  logic [PTR_W-1:0]        ptr_q;
  logic [NUM_REQ-1:0]      owner_q;
  logic [ADDR_WIDTH-1:0]   pend_addr_q;
  logic [NUM_REQ-1:0]      resp_valid_q;
  logic [LANE_WIDTH-1:0]   resp_data_q;
  logic [ADDR_WIDTH-1:0]   resp_addr_q;
  logic                    mem_req_valid_q;
  logic [ADDR_WIDTH-1:0]   mem_req_addr_q;

  logic                    grant_found;
  logic [PTR_W-1:0]        grant_idx;
  logic [PTR_W-1:0]        cand;
  logic [NUM_REQ-1:0]      grant_onehot;
  logic [NUM_REQ-1:0]      merge_vec;
  logic [PTR_W-1:0]        ptr_d;

  // Round-robin search: first valid requester at or above the pointer, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!grant_found && req_valid_i[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign grant_onehot = grant_found ? (NUM_REQ'(1) << grant_idx) : '0;
  assign ptr_d        = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);

`ifdef INSTR_ARB_MERGE_EN
  // A requester joins the outstanding miss when it targets the same line.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_merge
    assign merge_vec[gi] = (state_q != IDLE) && req_valid_i[gi] && !owner_q[gi] &&
                           (req_address_i[gi][ADDR_WIDTH-1:OFFSET_BITS] ==
                            pend_addr_q[ADDR_WIDTH-1:OFFSET_BITS]);
  end
`else
  assign merge_vec = '0;
`endif

  // Accepts come from the IDLE winner, or from same-line merges while busy.
  assign req_ready_o = (state_q == IDLE) ? grant_onehot : merge_vec;

  // Main FSM: grant, issue to memory, wait for the lane, return it to the owners.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= IDLE;
      ptr_q           <= '0;
      owner_q         <= '0;
      pend_addr_q     <= '0;
      resp_valid_q    <= '0;
      resp_data_q     <= '0;
      resp_addr_q     <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
    end else begin
      mem_req_valid_q <= 1'b0;
      resp_valid_q    <= '0;
      case (state_q)
        IDLE: begin
          if (grant_found) begin
            pend_addr_q <= req_address_i[grant_idx];
            owner_q     <= grant_onehot;
            ptr_q       <= ptr_d;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          owner_q <= owner_q | merge_vec;
          if (mem_request_available_i) begin
            mem_req_valid_q <= 1'b1;
            mem_req_addr_q  <= pend_addr_q;
            state_q         <= WAIT_MEM;
          end
        end
        WAIT_MEM: begin
          owner_q <= owner_q | merge_vec;
          if (mem_response_valid_i) begin
            resp_valid_q <= owner_q | merge_vec;
            resp_data_q  <= mem_response_data_i;
            resp_addr_q  <= pend_addr_q;
            owner_q      <= '0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign resp_valid_o          = resp_valid_q;
  assign resp_data_o           = resp_data_q;
  assign resp_address_o        = resp_addr_q;
  assign mem_request_valid_o   = mem_req_valid_q;
  assign mem_request_address_o = mem_req_addr_q;
  assign busy_o                = (state_q != IDLE);

endmodule

// File: tb/tb_instr_mem_arbiter.sv
// Self-checking bench for instr_mem_arbiter: a transaction-level model checked
// every cycle, plus directed literal checks. Honours INSTR_ARB_MERGE_EN.
module tb_instr_mem_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int LW = 512;
  localparam int OB = 6;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [N-1:0]           req_valid;
  logic [N-1:0][AW-1:0]   req_addr;
  logic [N-1:0]           req_ready;
  logic [N-1:0]           resp_valid;
  logic [LW-1:0]          resp_data;
  logic [AW-1:0]          resp_addr;
  logic                   avail;
  logic                   mreq_valid;
  logic [AW-1:0]          mreq_addr;
  logic                   mrv;
  logic [LW-1:0]          mrd;
  logic                   busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_mem_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .LANE_WIDTH(LW), .OFFSET_BITS(OB)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_address_i(req_addr), .req_ready_o(req_ready),
    .resp_valid_o(resp_valid), .resp_data_o(resp_data), .resp_address_o(resp_addr),
    .mem_request_available_i(avail), .mem_request_valid_o(mreq_valid),
    .mem_request_address_o(mreq_addr), .mem_response_valid_i(mrv),
    .mem_response_data_i(mrd), .busy_o(busy)
  );

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int            m_phase;   // 0 idle, 1 waiting for the port, 2 waiting for data
  int            m_ptr;
  logic [N-1:0]  m_owner;
  logic [AW-1:0] m_pend;
  logic [N-1:0]  e_rv;
  logic [LW-1:0] e_rd;
  logic [AW-1:0] e_ra;
  logic          e_mv;
  logic [AW-1:0] e_ma;
  int            grants[$];

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] merges();
    logic [N-1:0] r;
    r = '0;
`ifdef INSTR_ARB_MERGE_EN
    for (int j = 0; j < N; j++)
      if (req_valid[j] && !m_owner[j] && ((req_addr[j] >> OB) == (m_pend >> OB))) r[j] = 1'b1;
`endif
    return r;
  endfunction

  // Compare every cycle on the falling edge, then advance the model.
  always @(negedge clk) begin
    logic [N-1:0] exp_rdy;
    logic [N-1:0] mg;
    int w;
    if (!rst_n) begin
      m_phase = 0; m_ptr = 0; m_owner = '0; m_pend = '0;
      e_rv = '0; e_rd = '0; e_ra = '0; e_mv = 1'b0; e_ma = '0;
    end
    mg = (m_phase != 0) ? merges() : '0;
    w  = pick(req_valid, m_ptr);
    exp_rdy = mg;
    if (m_phase == 0 && w >= 0) exp_rdy = N'(1) << w;
    chk("req_ready", LW'(req_ready), LW'(exp_rdy));
    chk("resp_valid", LW'(resp_valid), LW'(e_rv));
    chk("resp_data", resp_data, e_rd);
    chk("resp_address", LW'(resp_addr), LW'(e_ra));
    chk("mem_request_valid", LW'(mreq_valid), LW'(e_mv));
    if (e_mv || !rst_n) chk("mem_request_address", LW'(mreq_addr), LW'(e_ma));
    chk("busy", LW'(busy), LW'(m_phase != 0));
    if (m_phase == 0)
      for (int i = 0; i < N; i++) if (req_ready[i]) grants.push_back(i);
    if (rst_n) begin
      e_mv = 1'b0;
      e_rv = '0;
      if (m_phase == 0) begin
        if (w >= 0) begin
          m_pend = req_addr[w]; m_owner = N'(1) << w; m_ptr = (w + 1) % N; m_phase = 1;
        end
      end else if (m_phase == 1) begin
        m_owner = m_owner | mg;
        if (avail) begin e_mv = 1'b1; e_ma = m_pend; m_phase = 2; end
      end else begin
        m_owner = m_owner | mg;
        if (mrv) begin
          e_rv = m_owner; e_rd = mrd; e_ra = m_pend; m_owner = '0; m_phase = 0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] mk(input int s);
    return {16{s}};
  endfunction

  // Wait (bounded) for a memory request pulse, answer it lat cycles later.
  task automatic serve_one(input int lat, input logic [LW-1:0] d);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (mreq_valid) begin seen = 1'b1; break; end
    end
    chk("serve_timeout", LW'(seen), LW'(1));
    if (seen) begin
      repeat (lat) next_cyc();
      mrv = 1'b1; mrd = d;
      next_cyc();
      mrv = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_order[6];
    exp_order = '{0, 1, 2, 3, 0, 1};
    rst_n = 1'b1; req_valid = '0; req_addr = '0; avail = 1'b0; mrv = 1'b0; mrd = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Round-robin fairness: all valid, each answered 3 cycles after issue.
    for (int i = 0; i < N; i++) req_addr[i] = AW'(32'h10000 * (i + 1));
    req_valid = 4'b1111; avail = 1'b1;
    for (int i = 0; i < 6; i++) begin
      serve_one(3, mk(32'hC0DE0000 + i));
      if (i == 5) req_valid = '0;
    end
    next_cyc();
    chk("grant_count", LW'(grants.size()), LW'(6));
    for (int i = 0; i < 6; i++)
      if (i < grants.size()) chk("grant_order", LW'(grants[i]), LW'(exp_order[i]));

    // Single request with hand-computed timing.
    next_cyc();
    req_valid = 4'b0001; req_addr[0] = 32'h1000; avail = 1'b1;
    @(negedge clk); chk("t1_ready_c0", LW'(req_ready), LW'(4'b0001));
    next_cyc(); req_valid = '0;
    next_cyc();
    @(negedge clk);
    chk("t1_mreq_valid_c2", LW'(mreq_valid), LW'(1));
    chk("t1_mreq_addr_c2", LW'(mreq_addr), LW'(32'h1000));
    next_cyc(); next_cyc(); next_cyc();
    mrv = 1'b1; mrd = mk(32'hDEADBEEF);
    next_cyc(); mrv = 1'b0;
    @(negedge clk);
    chk("t1_resp_valid_c6", LW'(resp_valid), LW'(4'b0001));
    chk("t1_resp_data_c6", resp_data, mk(32'hDEADBEEF));
    chk("t1_resp_addr_c6", LW'(resp_addr), LW'(32'h1000));
    chk("t1_busy_c6", LW'(busy), LW'(0));

    // Spurious response in IDLE, then in ISSUE.
    next_cyc(); mrv = 1'b1; mrd = mk(32'h11111111);
    next_cyc(); mrv = 1'b0;
    @(negedge clk);
    chk("spur_idle_resp", LW'(resp_valid), LW'(0));
    chk("spur_idle_busy", LW'(busy), LW'(0));
    next_cyc(); avail = 1'b0; req_valid = 4'b0010; req_addr[1] = 32'h7000;
    next_cyc(); req_valid = '0; mrv = 1'b1;
    next_cyc(); mrv = 1'b0;
    @(negedge clk);
    chk("spur_issue_resp", LW'(resp_valid), LW'(0));
    chk("spur_issue_busy", LW'(busy), LW'(1));
    chk("spur_issue_mreq", LW'(mreq_valid), LW'(0));
    next_cyc(); avail = 1'b1;
    serve_one(2, mk(32'h22222222));

    // Backpressure: port unavailable for cycles 1-4 after accept.
    next_cyc(); req_valid = 4'b0100; req_addr[2] = 32'h3000; avail = 1'b0;
    next_cyc(); req_valid = '0;
    for (int c = 2; c <= 4; c++) begin
      next_cyc(); @(negedge clk); chk("bp_hold", LW'(mreq_valid), LW'(0));
    end
    next_cyc(); avail = 1'b1; @(negedge clk); chk("bp_c5", LW'(mreq_valid), LW'(0));
    next_cyc(); @(negedge clk);
    chk("bp_c6_pulse", LW'(mreq_valid), LW'(1));
    chk("bp_c6_addr", LW'(mreq_addr), LW'(32'h3000));
    next_cyc(); @(negedge clk); chk("bp_c7_nodup", LW'(mreq_valid), LW'(0));
    next_cyc(); mrv = 1'b1; mrd = mk(32'h33333333);
    next_cyc(); mrv = 1'b0; @(negedge clk); chk("bp_resp", LW'(resp_valid), LW'(4'b0100));

    // Same-line merge during WAIT_MEM.
    next_cyc(); req_valid = 4'b0001; req_addr[0] = 32'h1000;
    next_cyc(); req_valid = '0;
    next_cyc();
    next_cyc(); req_valid = 4'b1100; req_addr[2] = 32'h1020; req_addr[3] = 32'h2000;
    @(negedge clk);
`ifdef INSTR_ARB_MERGE_EN
    chk("merge_ready", LW'(req_ready), LW'(4'b0100));
    next_cyc(); req_valid = 4'b1000; mrv = 1'b1; mrd = mk(32'h44444444);
    next_cyc(); mrv = 1'b0; @(negedge clk);
    chk("merge_resp", LW'(resp_valid), LW'(4'b0101));
    chk("merge_next_ready", LW'(req_ready), LW'(4'b1000));
    next_cyc(); req_valid = '0;
    serve_one(2, mk(32'h55555555));
`else
    chk("merge_ready", LW'(req_ready), LW'(4'b0000));
    next_cyc(); mrv = 1'b1; mrd = mk(32'h44444444);
    next_cyc(); mrv = 1'b0; @(negedge clk);
    chk("merge_resp", LW'(resp_valid), LW'(4'b0001));
    chk("merge_next_ready", LW'(req_ready), LW'(4'b0100));
    next_cyc(); req_valid = 4'b1000;
    serve_one(2, mk(32'h55555555));
    next_cyc(); req_valid = '0;
    serve_one(2, mk(32'h66666666));
`endif

    // Reset in WAIT_MEM, then a late response after release.
    next_cyc(); req_valid = 4'b0100; req_addr[2] = 32'h4000; avail = 1'b1;
    next_cyc(); req_valid = '0;
    next_cyc();
    next_cyc(); rst_n = 1'b0;
    @(negedge clk);
    chk("rst_busy", LW'(busy), LW'(0));
    chk("rst_resp_data", resp_data, LW'(0));
    next_cyc(); rst_n = 1'b1;
    next_cyc(); mrv = 1'b1; mrd = mk(32'h77777777);
    next_cyc(); mrv = 1'b0; @(negedge clk);
    chk("rst_late_resp", LW'(resp_valid), LW'(0));
    chk("rst_late_busy", LW'(busy), LW'(0));
    next_cyc(); req_valid = 4'b1010; req_addr[1] = 32'h5000; req_addr[3] = 32'h6000;
    @(negedge clk); chk("rst_ptr_zero", LW'(req_ready), LW'(4'b0010));
    next_cyc(); req_valid = '0;
    serve_one(2, mk(32'h88888888));
    next_cyc(); next_cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
